// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc_pkg
// Description : Shared types and constants for the tc_bank timer/counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_PRESET = 2'd1;
    localparam logic [1:0] c_REG_COUNT  = 2'd2;
    localparam logic [1:0] c_REG_STATUS = 2'd3;

    localparam int c_CTRL_EN       = 0;
    localparam int c_CTRL_MODE_LSB = 1;
    localparam int c_CTRL_MODE_MSB = 2;
    localparam int c_CTRL_IM       = 3;
    localparam int c_CTRL_PS_LSB   = 4;
    localparam int c_CTRL_PS_MSB   = 11;
    localparam int c_STATUS_PEND   = 0;

    localparam logic [1:0] c_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] c_MODE_RELOAD  = 2'b01;

    // Codes 10/11 fall back to one-shot behaviour.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == c_MODE_RELOAD) && (mode != c_MODE_ONESHOT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : tc_bank_if
// Description : Word-addressed device bus plus interrupt outputs of tc_bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface tc_bank_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 4
) ();

    logic [ADDR_W-1:0] Addr;
    logic              WE;
    logic [31:0]       Din;
    logic [31:0]       Dout;
    logic [N_CH-1:0]   IRQ;
    logic              IRQ_any;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout,
        input  IRQ,
        input  IRQ_any
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout,
        output IRQ,
        output IRQ_any
    );

endinterface
`default_nettype wire

// File: rtl/tc_channel.sv
`default_nettype none
// ============================================================================
// Module      : tc_channel
// Description : One down-counter channel: registers, FSM, prescaler, IRQ flop.
//               Optional prescaler enabled by macro TC_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_channel
    import tc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl_i,
    input  logic        wr_preset_i,
    input  logic        wr_status_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  rsel_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    tc_state_e        state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic             irq_q, irq_d;
    logic             w_tick;
    logic             w_last;

`ifdef TC_PRESCALE_EN
    logic [7:0]       ps_q, ps_d;
    logic [7:0]       pscnt_q, pscnt_d;
    assign w_tick = (pscnt_q == ps_q);
`else
    assign w_tick = 1'b1;
`endif

    // A preset of 0 terminates like a preset of 1.
    assign w_last = (count_q <= CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE looks at the post-write enable so a start costs no extra cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en_d) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_CNT;
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (w_tick && w_last) begin
                    state_d = ST_INT;
                end
            end
            ST_INT: state_d = is_reload(mode_q) ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
`ifdef TC_PRESCALE_EN
        ps_d     = ps_q;
        pscnt_d  = pscnt_q;
`endif
        if ((state_q == ST_INT) && !is_reload(mode_q)) begin
            en_d = 1'b0;
        end
        if (wr_ctrl_i) begin
            en_d   = wdata_i[c_CTRL_EN];
            mode_d = wdata_i[c_CTRL_MODE_MSB:c_CTRL_MODE_LSB];
            im_d   = wdata_i[c_CTRL_IM];
`ifdef TC_PRESCALE_EN
            ps_d   = wdata_i[c_CTRL_PS_MSB:c_CTRL_PS_LSB];
`endif
        end
        if (wr_preset_i) begin
            preset_d = wdata_i[CNT_W-1:0];
        end
        case (state_q)
            ST_LOAD: begin
                count_d = preset_q;
`ifdef TC_PRESCALE_EN
                pscnt_d = '0;
`endif
            end
            ST_CNT: begin
                if (en_q) begin
`ifdef TC_PRESCALE_EN
                    pscnt_d = w_tick ? 8'd0 : (pscnt_q + 8'd1);
`endif
                    if (w_tick) begin
                        count_d = w_last ? '0 : (count_q - CNT_W'(1));
                    end
                end
            end
            default: ;
        endcase
        if (wr_status_i && wdata_i[c_STATUS_PEND]) begin
            pend_d = 1'b0;
        end
        if (state_q == ST_INT) begin
            pend_d = 1'b1;
        end
        irq_d = pend_d & im_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
`ifdef TC_PRESCALE_EN
            ps_q     <= '0;
            pscnt_q  <= '0;
`endif
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
`ifdef TC_PRESCALE_EN
            ps_q     <= ps_d;
            pscnt_q  <= pscnt_d;
`endif
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (rsel_i)
            c_REG_CTRL: begin
                rdata_o[c_CTRL_EN]                       = en_q;
                rdata_o[c_CTRL_MODE_MSB:c_CTRL_MODE_LSB] = mode_q;
                rdata_o[c_CTRL_IM]                       = im_q;
`ifdef TC_PRESCALE_EN
                rdata_o[c_CTRL_PS_MSB:c_CTRL_PS_LSB]     = ps_q;
`endif
            end
            c_REG_PRESET: rdata_o = 32'(preset_q);
            c_REG_COUNT:  rdata_o = 32'(count_q);
            c_REG_STATUS: rdata_o[c_STATUS_PEND] = pend_q;
            default: ;
        endcase
    end

    assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: rtl/tc_bank.sv
`default_nettype none
// ============================================================================
// Module      : tc_bank
// Description : N_CH-channel timer/counter bank: address decode, read mux and
//               IRQ reduction. Prescaler option selected by TC_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_bank
    import tc_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    tc_bank_if.slave   bus
);

    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_ch_idx;
    logic              w_hit;
    logic [1:0]        w_rsel;
    logic [31:0]       w_rdata [N_CH];
    logic [N_CH-1:0]   w_irq;

    assign w_addr   = bus.Addr;
    assign w_ch_idx = 32'(w_addr) >> 2;
    assign w_hit    = (w_ch_idx < 32'(N_CH));
    assign w_rsel   = w_addr[1:0];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic w_we;
        assign w_we = bus.WE && w_hit && (w_ch_idx == 32'(gi));

        tc_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk         (clk),
            .rst         (reset),
            .wr_ctrl_i   (w_we && (w_rsel == c_REG_CTRL)),
            .wr_preset_i (w_we && (w_rsel == c_REG_PRESET)),
            .wr_status_i (w_we && (w_rsel == c_REG_STATUS)),
            .wdata_i     (bus.Din),
            .rsel_i      (w_rsel),
            .rdata_o     (w_rdata[gi]),
            .irq_o       (w_irq[gi])
        );
    end

    // Unmapped channels read as zero.
    always_comb begin
        bus.Dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_hit && (w_ch_idx == 32'(i))) begin
                bus.Dout = w_rdata[i];
            end
        end
    end

    assign bus.IRQ     = w_irq;
    assign bus.IRQ_any = |w_irq;

endmodule
`default_nettype wire
